// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: load-use and divide stalls, divider
// start/abort sequencing with timeout, and a saturating stall-cycle counter.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no divide in flight; load-use hazard may freeze PC/IF/ID
// BUSY  | divider running; PC/IF/ID/EX frozen, counting down to timeout
// DONE  | result cycle; EX captures the quotient unless flushed
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id,
    input  logic        ex_div_req,
    input  logic        ex_flush,
    input  logic        div_ready,
    output logic [5:0]  stall,
    output logic        div_start,
    output logic        div_abort,
    output logic        div_result_valid,
    output logic        div_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(DIV_CYCLES - 1);
    localparam logic [5:0]       STALL_FRONT = 6'b000111;
    localparam logic [5:0]       STALL_EX    = 6'b001111;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_q;
    logic             timeout_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        stall            = '0;
        div_start        = 1'b0;
        div_abort        = 1'b0;
        div_result_valid = 1'b0;
        timeout_set      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ex_div_req && !ex_flush) begin
                    div_start = 1'b1;
                    stall     = STALL_EX;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_LOAD;
                end else if (stallreq_id && !ex_flush) begin
                    stall = STALL_FRONT;
                end
            end
            ST_BUSY: begin
                if (ex_flush) begin
                    div_abort = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    stall = STALL_EX;
                    if (div_ready) begin
                        state_nxt = ST_DONE;
                    end else if (cnt == '0) begin
                        timeout_set = 1'b1;
                        state_nxt   = ST_DONE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // The divide leaves EX here, so a still-high request cannot retrigger.
                div_result_valid = !ex_flush;
                state_nxt        = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Flag is visible in the very cycle the timeout is detected, then sticks.
    assign div_timeout = timeout_q | timeout_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((stall != '0) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: reset, load-use, divide, flush,
// timeout and reset-mid-divide scenarios with hand-computed expectations.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stallreq_id;
    logic        ex_div_req;
    logic        ex_flush;
    logic        div_ready;
    logic [5:0]  stall;
    logic        div_start;
    logic        div_abort;
    logic        div_result_valid;
    logic        div_timeout;
    logic [31:0] stall_cycles;

    int n_vec;
    int n_err;

    pipe_stall_ctrl #(.DIV_CYCLES(33), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stallreq_id      (stallreq_id),
        .ex_div_req       (ex_div_req),
        .ex_flush         (ex_flush),
        .div_ready        (div_ready),
        .stall            (stall),
        .div_start        (div_start),
        .div_abort        (div_abort),
        .div_result_valid (div_result_valid),
        .div_timeout      (div_timeout),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to the next cycle; inputs are changed 1ns after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sr, input logic dr, input logic fl, input logic rdy);
        stallreq_id = sr;
        ex_div_req  = dr;
        ex_flush    = fl;
        div_ready   = rdy;
        #2;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("rst_cnt", stall_cycles, 32'd0);
            chk("rst_tmo", {31'd0, div_timeout}, 32'd0);
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rel_stall", {26'd0, stall}, 32'd0);
        chk("rel_start", {31'd0, div_start}, 32'd0);
        chk("rel_rv", {31'd0, div_result_valid}, 32'd0);
        chk("rel_cnt", stall_cycles, 32'd0);

        // Load-use for two cycles
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_stall0", {26'd0, stall}, 32'h07);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_stall1", {26'd0, stall}, 32'h07);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall2", {26'd0, stall}, 32'd0);
        chk("lu_cnt", stall_cycles, 32'd2);

        // Normal divide: request at t, ready at t+32
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dv_start", {31'd0, div_start}, 32'd1);
        chk("dv_stall_t", {26'd0, stall}, 32'h0F);
        for (int i = 1; i <= 31; i++) begin
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk("dv_busy_stall", {26'd0, stall}, 32'h0F);
            chk("dv_busy_start", {31'd0, div_start}, 32'd0);
        end
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk("dv_rdy_stall", {26'd0, stall}, 32'h0F);
        chk("dv_rdy_rv", {31'd0, div_result_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dv_done_stall", {26'd0, stall}, 32'd0);
        chk("dv_done_rv", {31'd0, div_result_valid}, 32'd1);
        chk("dv_done_start", {31'd0, div_start}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("dv_idle_rv", {31'd0, div_result_valid}, 32'd0);
        chk("dv_idle_stall", {26'd0, stall}, 32'd0);
        chk("dv_cnt", stall_cycles, 32'd35);
        chk("dv_tmo", {31'd0, div_timeout}, 32'd0);

        // Simultaneous request, then flush 5 cycles into BUSY
        next_cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim_stall", {26'd0, stall}, 32'h0F);
        chk("sim_start", {31'd0, div_start}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            chk("fl_busy_stall", {26'd0, stall}, 32'h0F);
        end
        next_cycle();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("fl_abort", {31'd0, div_abort}, 32'd1);
        chk("fl_stall", {26'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("fl_after_abort", {31'd0, div_abort}, 32'd0);
        chk("fl_after_rv", {31'd0, div_result_valid}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_idle_lu", {26'd0, stall}, 32'h07);
        chk("fl_idle_rv", {31'd0, div_result_valid}, 32'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("idle_flush_lu", {26'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_flush_div_start", {31'd0, div_start}, 32'd0);
        chk("idle_flush_div_stall", {26'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_rdy_rv", {31'd0, div_result_valid}, 32'd0);
        chk("idle_rdy_stall", {26'd0, stall}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_rdy_rv2", {31'd0, div_result_valid}, 32'd0);
        chk("fl_cnt", stall_cycles, 32'd41);

        // Timeout: no div_ready
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_start", {31'd0, div_start}, 32'd1);
        for (int i = 1; i <= 32; i++) begin
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk("to_pre", {31'd0, div_timeout}, 32'd0);
            chk("to_pre_stall", {26'd0, stall}, 32'h0F);
        end
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_rise", {31'd0, div_timeout}, 32'd1);
        chk("to_rise_stall", {26'd0, stall}, 32'h0F);
        chk("to_rise_rv", {31'd0, div_result_valid}, 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("to_done_rv", {31'd0, div_result_valid}, 32'd1);
        chk("to_done_stall", {26'd0, stall}, 32'd0);
        chk("to_done_flag", {31'd0, div_timeout}, 32'd1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_cnt", stall_cycles, 32'd75);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("to_sticky", {31'd0, div_timeout}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("to_clr", {31'd0, div_timeout}, 32'd0);
        chk("to_clr_cnt", stall_cycles, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Reset in the middle of a divide
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mr_start", {31'd0, div_start}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("mr_busy", {26'd0, stall}, 32'h0F);
        stallreq_id = 1'b0;
        ex_div_req  = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("mr_stall", {26'd0, stall}, 32'd0);
        chk("mr_abort", {31'd0, div_abort}, 32'd0);
        chk("mr_cnt", stall_cycles, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mr_idle_lu", {26'd0, stall}, 32'h07);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mr_final_cnt", stall_cycles, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall controller for the five-stage pipeline. Generates the 6-bit `stall` bus consumed by the PC, IF, ID, EX, MEM and WB pipeline registers. Sequences the shared multi-cycle divider through a start/busy/done state machine that holds the front of the pipeline until the result is ready. Also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `DIV_CYCLES`, default 33: maximum BUSY cycles allowed for one divide before timeout; legal range 2..255.
- `CNT_W`, default 8: width of the busy countdown; must hold `DIV_CYCLES-1`.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stallreq_id` input 1: load-use hazard request from ID; combinational, level.
- `ex_div_req` input 1: EX holds a div/divu instruction; level, held until the instruction leaves EX.
- `ex_flush` input 1: exception flush of EX and earlier stages; single-cycle pulse.
- `div_ready` input 1: divider result valid; single-cycle pulse.
- `stall` output `StallBus` (6): bit i = `Stop` (1) freezes stage i. Bit mapping: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- `div_start` output 1: one-cycle pulse that launches the divider.
- `div_abort` output 1: one-cycle pulse that cancels an in-flight divide.
- `div_result_valid` output 1: high for the one cycle in which EX may capture the divide result.
- `div_timeout` output 1: sticky error flag; cleared only by reset.
- `stall_cycles` output 32: saturating count of cycles with `stall != 0`.

## Operation
- **State machine.** States IDLE, BUSY, DONE; held in registers. `cnt` is a `CNT_W`-bit register.
- **IDLE**
  - `ex_div_req && !ex_flush`: `div_start=1` and `stall=6'b001111` in the same cycle; next state BUSY, `cnt <= DIV_CYCLES-1`.
  - Otherwise, `stallreq_id && !ex_flush`: `stall=6'b000111`.
  - Else: `stall=0`.
- **BUSY**
  - `stall=6'b001111` every cycle. `stallreq_id` is ignored (covered by the EX stall).
  - `ex_flush`: `div_abort=1`, `stall=0`, next state IDLE.
  - Else `div_ready`: next state DONE.
  - Else `cnt==0`: set `div_timeout`, next state DONE.
  - Else: `cnt <= cnt-1`.
- **DONE**
  - `stall=0`. The divide instruction leaves EX this cycle, which prevents a retrigger.
  - `div_result_valid = !ex_flush`. Next state is always IDLE.
  - `stallreq_id` is ignored in DONE; the hazard re-evaluates in IDLE next cycle.
- **Outputs.** `stall`, `div_start`, `div_abort` and `div_result_valid` are combinational from state and inputs, with no extra register stage.
- **Priority** within a cycle: `ex_flush` > `ex_div_req` / BUSY > `stallreq_id`.
- **Stall cycle counter.** `stall_cycles` increments by 1 on every cycle in which `stall != 0`. It saturates at `32'hFFFF_FFFF` and never wraps.
- **`div_ready` outside BUSY** is ignored, with no state change.
- **Reset.** `rst_n` low at any time, including mid-BUSY, forces state IDLE, `cnt=0`, `div_timeout=0`, `stall_cycles=0`. With inputs low this gives `stall=0`, `div_start=0`, `div_abort=0`, `div_result_valid=0`. No abort pulse is produced by reset.

## Timing
- **Divide request.** `ex_div_req` first high at cycle t in IDLE:
  - `div_start` at t.
  - BUSY from t+1.
- **Divider completion.** `div_ready` at cycle t+k (k≥1, in BUSY):
  - DONE at t+k+1 with `stall=0` and `div_result_valid=1`.
  - IDLE at t+k+2.
  - Stall held for cycles t..t+k, i.e. k+1 cycles.
- **Timeout.** Without `div_ready`, the last BUSY cycle is t+DIV_CYCLES; timeout is flagged there and DONE follows at t+DIV_CYCLES+1.
- **Back-to-back divides.** The earliest second `div_start` is the cycle after DONE, so there is a minimum 1 IDLE cycle between divides.
- **Load-use stall.** Zero latency: `stall` follows `stallreq_id` in the same cycle when IDLE.

## Test plan
- **Reset:** hold `rst_n=0` with random inputs, then release -> `stall=0`, `stall_cycles=0`, `div_timeout=0`, state IDLE.
- **Load-use only:** `stallreq_id=1` for 2 cycles in IDLE -> `stall=6'b000111` for exactly those 2 cycles; `stall_cycles=2`.
- **Normal divide:** `ex_div_req` at cycle 10, `div_ready` at cycle 42 ->
  - `div_start` at 10;
  - `stall=6'b001111` for cycles 10..42;
  - `div_result_valid` at 43;
  - IDLE at 44;
  - `stall_cycles=33`.
- **Simultaneous requests:** `ex_div_req=1` and `stallreq_id=1` at the same cycle in IDLE -> `stall=6'b001111` and `div_start=1`.
- **Flush mid-divide:** `ex_flush` 5 cycles into BUSY -> `div_abort=1` and `stall=0` that cycle; IDLE next cycle; no `div_result_valid`.
- **Timeout:** `DIV_CYCLES=33` with `div_ready` never asserted ->
  - `div_timeout` rises at start+33;
  - `div_result_valid` at start+34;
  - the flag persists until `rst_n` goes low.
